// File: rtl/registrador_pkg.sv
// Shared types for the parametrised bus register: opcode encoding and the
// shift-engine state enum. Optional feature macro: REGISTRADOR_FLAGS_EN.
package registrador_pkg;

  localparam int unsigned OP_WIDTH = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OpClear   = 4'd0,
    OpLoad    = 4'd1,
    OpHold    = 4'd2,
    OpShiftR  = 4'd3,
    OpShiftL  = 4'd4,
    OpRotR    = 4'd5,
    OpRotL    = 4'd6,
    OpInc     = 4'd7,
    OpDec     = 4'd8,
    OpShiftRN = 4'd9,
    OpShiftLN = 4'd10
  } op_t;

  typedef enum logic [0:0] {
    StIdle,
    StShifting
  } shift_state_t;

endpackage

// File: rtl/registrador_shift_ctrl.sv
// Multi-cycle shift engine control: saturates the shift amount, counts the
// remaining steps and generates busy/done plus the per-cycle step strobe.
module registrador_shift_ctrl
  import registrador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start_i,  // SHIFTxN accepted while idle
  input  logic           left_i,   // direction of the accepted shift
  input  logic [SHW-1:0] shamt_i,
  input  logic           abort_i,  // CLEAR while busy
  output logic           busy_o,
  output logic           done_o,
  output logic           step_o,   // datapath shifts one bit this cycle
  output logic           left_o
);

  shift_state_t   state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           left_q, left_d;
  logic           done_q, done_d;
  logic [SHW-1:0] shamt_sat;

  // Amounts beyond the register width are clamped; the result is all zeros anyway.
  always_comb begin
    shamt_sat = (shamt_i > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt_i;
  end

  // Next-state logic for the shift FSM and its step counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    done_d  = 1'b0;
    step_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (shamt_sat == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = shamt_sat;
            left_d  = left_i;
            state_d = StShifting;
          end
        end
      end
      StShifting: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          step_o = 1'b1;
          cnt_d  = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, direction and done registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == StShifting);
  assign done_o = done_q;
  assign left_o = left_q;

endmodule

// File: rtl/registrador_param.sv
// WIDTH-bit data-bus register driven by a 4-bit opcode each cycle, with
// single-cycle shifts/rotates/inc/dec and a multi-cycle shift-by-N engine.
// Optional feature macro: REGISTRADOR_FLAGS_EN adds zero/carry/overflow flags.
module registrador_param
  import registrador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    entrada,
  input  logic                serial_in,
  input  logic [SHW-1:0]      shamt,
  output logic [WIDTH-1:0]    barramentodados,
  output logic                serial_out,
  output logic                busy,
  output logic                done
`ifdef REGISTRADOR_FLAGS_EN
  ,
  output logic                zero,
  output logic                carry,
  output logic                overflow
`endif
);

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             sout_q, sout_d;
  logic             start, abort, step, step_left;

  registrador_shift_ctrl #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shift_ctrl (
    .clock  (clock),
    .reset_n(reset_n),
    .start_i(start),
    .left_i (op == OpShiftLN),
    .shamt_i(shamt),
    .abort_i(abort),
    .busy_o (busy),
    .done_o (done),
    .step_o (step),
    .left_o (step_left)
  );

  // Datapath mux: while busy only CLEAR is honoured, otherwise decode the opcode.
  always_comb begin
    bus_d  = bus_q;
    sout_d = sout_q;
    start  = 1'b0;
    abort  = 1'b0;
    if (busy) begin
      if (op == OpClear) begin
        bus_d = '0;
        abort = 1'b1;
      end else if (step) begin
        if (step_left) begin
          sout_d = bus_q[WIDTH-1];
          bus_d  = {bus_q[WIDTH-2:0], 1'b0};
        end else begin
          sout_d = bus_q[0];
          bus_d  = {1'b0, bus_q[WIDTH-1:1]};
        end
      end
    end else begin
      case (op)
        OpClear:  bus_d = '0;
        OpLoad:   bus_d = entrada;
        OpShiftR: begin
          sout_d = bus_q[0];
          bus_d  = {serial_in, bus_q[WIDTH-1:1]};
        end
        OpShiftL: begin
          sout_d = bus_q[WIDTH-1];
          bus_d  = {bus_q[WIDTH-2:0], serial_in};
        end
        OpRotR: begin
          sout_d = bus_q[0];
          bus_d  = {bus_q[0], bus_q[WIDTH-1:1]};
        end
        OpRotL: begin
          sout_d = bus_q[WIDTH-1];
          bus_d  = {bus_q[WIDTH-2:0], bus_q[WIDTH-1]};
        end
        OpInc:    bus_d = bus_q + WIDTH'(1);
        OpDec:    bus_d = bus_q - WIDTH'(1);
        OpShiftRN, OpShiftLN: start = 1'b1;
        default:  ;
      endcase
    end
  end

  // Bus and serial-out registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_q  <= '0;
      sout_q <= 1'b0;
    end else begin
      bus_q  <= bus_d;
      sout_q <= sout_d;
    end
  end

  assign barramentodados = bus_q;
  assign serial_out      = sout_q;

`ifdef REGISTRADOR_FLAGS_EN
  logic wr, cy, ov;

  // Flags refresh only on cycles that write the register.
  always_comb begin
    if (busy) begin
      wr = (op == OpClear) || step;
      cy = 1'b0;
      ov = 1'b0;
    end else begin
      wr = op inside {OpClear, OpLoad, OpShiftR, OpShiftL, OpRotR, OpRotL, OpInc, OpDec};
      cy = ((op == OpInc) && (&bus_q)) || ((op == OpDec) && ~|bus_q);
      ov = ((op == OpInc) && (bus_q == {1'b0, {(WIDTH-1){1'b1}}})) ||
           ((op == OpDec) && (bus_q == {1'b1, {(WIDTH-1){1'b0}}}));
    end
  end

  // Flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (wr) begin
      zero     <= (bus_d == '0);
      carry    <= cy;
      overflow <= ov;
    end
  end
`endif

endmodule

// File: tb/tb_registrador_param.sv
// Scoreboard bench for registrador_param (WIDTH=8): the driver pushes the
// reference model's expected outputs, a monitor pops and compares each cycle.
module tb_registrador_param;
  import registrador_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned SHW = $clog2(W) + 1;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [3:0]     op = 4'd2;
  logic [W-1:0]   entrada = '0;
  logic           serial_in = 1'b0;
  logic [SHW-1:0] shamt = '0;
  logic [W-1:0]   barramentodados;
  logic           serial_out, busy, done;
`ifdef REGISTRADOR_FLAGS_EN
  logic           zero, carry, overflow;
`endif

  registrador_param #(.WIDTH(W), .SHW(SHW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .op             (op),
    .entrada        (entrada),
    .serial_in      (serial_in),
    .shamt          (shamt),
    .barramentodados(barramentodados),
    .serial_out     (serial_out),
    .busy           (busy),
    .done           (done)
`ifdef REGISTRADOR_FLAGS_EN
    ,
    .zero           (zero),
    .carry          (carry),
    .overflow       (overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] bus;
    logic         sout;
    logic         busy;
    logic         done;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: bus value, remaining shift steps, direction.
  int unsigned m_bus;
  logic        m_sout, m_done, m_left, m_z, m_c, m_v;
  int          m_left_steps;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.bus  = m_bus[W-1:0];
    e.sout = m_sout;
    e.busy = (m_left_steps > 0);
    e.done = m_done;
    e.z    = m_z;
    e.c    = m_c;
    e.v    = m_v;
    return e;
  endfunction

  task automatic model_reset();
    m_bus = 0; m_sout = 0; m_done = 0; m_left = 0;
    m_z = 0; m_c = 0; m_v = 0; m_left_steps = 0;
  endtask

  task automatic set_flags(input logic c, input logic v);
    m_z = (m_bus == 0);
    m_c = c;
    m_v = v;
  endtask

  // One clock of the specified behaviour, in plain arithmetic.
  task automatic model_step(input int o, input int unsigned ent, input logic sin,
                            input int unsigned sh);
    int unsigned mask = (1 << W) - 1;
    int unsigned msb  = 1 << (W - 1);
    m_done = 0;
    if (m_left_steps > 0) begin
      if (o == 0) begin
        m_bus = 0; m_left_steps = 0; set_flags(0, 0);
      end else begin
        if (m_left) begin
          m_sout = (m_bus & msb) != 0;
          m_bus  = (m_bus * 2) & mask;
        end else begin
          m_sout = m_bus[0];
          m_bus  = m_bus / 2;
        end
        m_left_steps--;
        if (m_left_steps == 0) m_done = 1;
        set_flags(0, 0);
      end
    end else begin
      case (o)
        0: begin m_bus = 0; set_flags(0, 0); end
        1: begin m_bus = ent & mask; set_flags(0, 0); end
        3: begin m_sout = m_bus[0]; m_bus = (m_bus / 2) | (sin ? msb : 0); set_flags(0, 0); end
        4: begin m_sout = (m_bus & msb) != 0; m_bus = ((m_bus * 2) | sin) & mask; set_flags(0, 0); end
        5: begin m_sout = m_bus[0]; m_bus = (m_bus / 2) | (m_bus[0] ? msb : 0); set_flags(0, 0); end
        6: begin
          m_sout = (m_bus & msb) != 0;
          m_bus = ((m_bus * 2) | (m_sout ? 1 : 0)) & mask;
          set_flags(0, 0);
        end
        7: begin
          logic c = (m_bus == mask);
          logic v = (m_bus == msb - 1);
          m_bus = (m_bus + 1) & mask; set_flags(c, v);
        end
        8: begin
          logic c = (m_bus == 0);
          logic v = (m_bus == msb);
          m_bus = (m_bus + mask) & mask; set_flags(c, v);
        end
        9, 10: begin
          int unsigned n = (sh > W) ? W : sh;
          if (n == 0) m_done = 1;
          else begin m_left_steps = n; m_left = (o == 10); end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one opcode at the falling edge and queue the expected response.
  task automatic cyc(input int o, input int unsigned ent = 0, input logic sin = 0,
                     input int unsigned sh = 0);
    op = 4'(o); entrada = W'(ent); serial_in = sin; shamt = SHW'(sh);
    model_step(o, ent, sin, sh);
    q.push_back(model_exp());
    @(negedge clock);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_bus", barramentodados, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout", serial_out, 0);
    model_reset();
    q.push_back(model_exp());
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: every output sample after a rising edge is checked against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("bus", barramentodados, e.bus);
        check("serial_out", serial_out, e.sout);
        check("busy", busy, e.busy);
        check("done", done, e.done);
        check("busy_done_excl", busy & done, 0);
`ifdef REGISTRADOR_FLAGS_EN
        check("zero", zero, e.z);
        check("carry", carry, e.c);
        check("overflow", overflow, e.v);
`endif
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    // Load, shift right with serial_in, rotate back.
    cyc(1, 'hA5); cyc(3, 0, 1); cyc(6);
    // Increment/decrement wrap and signed overflow.
    cyc(1, 'hFF); cyc(7); cyc(8);
    cyc(1, 'h7F); cyc(7); cyc(8);
    // SHIFTRN by 3 with a LOAD ignored while busy.
    cyc(1, 'h81); cyc(9, 0, 0, 3); cyc(1, 'h55); cyc(2); cyc(2); cyc(2);
    // Zero and saturated shift amounts.
    cyc(10, 0, 0, 0); cyc(2);
    cyc(1, 'hFF); cyc(10, 0, 0, 9);
    for (int i = 0; i < 9; i++) cyc(2);
    // Abort with CLEAR on the second busy cycle, then reserved opcodes.
    cyc(1, 'hFF); cyc(9, 0, 0, 5); cyc(2); cyc(0); cyc(2); cyc(2);
    cyc(1, 'h3C);
    for (int o = 11; o < 16; o++) cyc(o, 'hFF, 1, 2);
    // Reset in the middle of a shift, then HOLD keeps zero.
    cyc(1, 'hF0); cyc(9, 0, 0, 4); cyc(2); cyc(2);
    do_reset();
    cyc(2); cyc(2);
    // Randomised traffic, biased toward short shift amounts.
    for (int i = 0; i < 400; i++) begin
      cyc(int'($urandom_range(0, 15)), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
    end
    @(posedge clock);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/registrador_param.md
Name: registrador_param

Overview:
- Parametrised successor of the 4-bit bus register: a WIDTH-bit data register driving the data bus.
- Controlled by a 4-bit opcode each clock.
- Adds single-bit shifts and rotates, increment and decrement, and a multi-cycle shift-by-N engine with busy/done handshake.
- Sits between the ALU/input mux and the data bus; the control FSM issues one opcode per cycle.

Parameters:
- WIDTH, 8, register and bus width in bits (min 2).
- SHW, $clog2(WIDTH)+1, width of the shift-amount port, so that shamt = WIDTH is representable.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- op  input  4  opcode, sampled every rising edge.
- entrada  input  WIDTH  parallel load data.
- serial_in  input  1  bit inserted by SHIFTR/SHIFTL.
- shamt  input  SHW  shift amount for SHIFTRN/SHIFTLN.
- barramentodados  output  WIDTH  registered data-bus value.
- serial_out  output  1  last bit shifted or rotated out (registered).
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse when a multi-cycle shift completes.

Behaviour:
- Reset (async, reset_n=0):
  - barramentodados=0, serial_out=0, busy=0, done=0.
  - FSM returns to IDLE and the shift counter is cleared, including mid-shift.
- Opcodes:
  - 0 CLEAR: bus<=0.
  - 1 LOAD: bus<=entrada.
  - 2 HOLD: no change.
  - 3 SHIFTR: bus<={serial_in,bus[W-1:1]}, serial_out<=bus[0].
  - 4 SHIFTL: bus<={bus[W-2:0],serial_in}, serial_out<=bus[W-1].
  - 5 ROTR: serial_out<=bus[0].
  - 6 ROTL: serial_out<=bus[W-1].
  - 7 INC: bus<=bus+1, modulo 2^WIDTH, wraps all-ones to 0.
  - 8 DEC: bus<=bus-1, wraps 0 to all-ones.
  - 9 SHIFTRN: logical right shift by shamt, zero fill.
  - 10 SHIFTLN: logical left shift by shamt, zero fill.
  - 11-15: treated as HOLD.
- Single-cycle ops (0-8) take effect at the sampling edge, with latency 1 to barramentodados.
- serial_out changes only on ops 3-6 and during SHIFTRN/SHIFTLN steps.
- FSM states: IDLE and SHIFTING.
- IDLE, op 9/10:
  - shamt=0: no shift, busy stays 0, done pulses on the next cycle.
  - shamt>=1: load counter=shamt, latch direction, go to SHIFTING, busy=1 from the next cycle.
- SHIFTING:
  - Each cycle shifts 1 bit (zero fill), updates serial_out, and decrements the counter.
  - On the step where the counter goes 1->0: busy<=0, done<=1 for exactly one cycle, return to IDLE.
  - Total latency: shamt cycles.
- shamt > WIDTH is saturated to WIDTH, giving result 0 after WIDTH cycles.
- While busy=1, every op except CLEAR is ignored, including LOAD and a new SHIFTxN.
- CLEAR while busy aborts the shift: bus<=0, busy<=0, no done pulse, IDLE.
- done and busy are never high in the same cycle.
- entrada and shamt are sampled only at acceptance. Later changes do not affect an in-flight shift.

Optional Feature:
- REGISTRADOR_FLAGS_EN defined:
  - Adds outputs zero (1), carry (1), overflow (1), all registered and reset to 0.
  - zero = (next bus == 0), updated on every register write.
  - carry = carry-out of INC or borrow of DEC, otherwise 0 on that write.
  - overflow = signed overflow of INC (0x7F->0x80 for W=8) or DEC (0x80->0x7F).
  - Flags hold during HOLD/ignored cycles.
- REGISTRADOR_FLAGS_EN undefined: ports absent, no flag logic.

Decomposition:
- Package registrador_pkg holds:
  - the op_t 4-bit enum with codes 0-10 as above;
  - the shift FSM state enum (IDLE, SHIFTING);
  - the localparam OP_WIDTH=4.
- One natural sub-module, registrador_shift_ctrl: counter, FSM, busy/done generation, and the saturation of shamt.
- The datapath mux stays in the top.

Test Plan:
1. WIDTH=8: reset_n=0 mid-SHIFTRN (bus=0xF0, shamt=4, after 2 steps) -> immediately bus=0, busy=0, done=0. After release, HOLD keeps 0.
2. LOAD 0xA5, then SHIFTR with serial_in=1 -> bus=0xD2, serial_out=1. Then ROTL -> bus=0xA5, serial_out=1.
3. LOAD 0xFF, INC -> bus=0x00 (carry=1, zero=1 with flags). Then DEC -> 0xFF (carry=1).
4. LOAD 0x81, SHIFTRN shamt=3 -> busy=1 for 3 cycles, bus steps 0x40, 0x20, 0x10, done pulses 1 cycle, serial_out=0. LOAD 0x55 issued while busy is ignored.
5. SHIFTLN with shamt=0 -> bus unchanged, busy never 1, done pulse next cycle. SHIFTLN with shamt=9 on 0xFF -> 8 cycles, result 0x00.
6. SHIFTRN shamt=5 on 0xFF, CLEAR at the 2nd busy cycle -> bus=0, busy=0 next cycle, no done pulse. Opcodes 11-15 -> bus unchanged.
